// File: rtl/rs_latch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rs_latch_sequencer_pkg
// Shared definitions for the RS-latch sequencer and its round-robin arbiter:
// FSM state encoding, command encoding, and the counter-width helper.
// -----------------------------------------------------------------------------
package rs_latch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic CMD_SET   = 1'b1;
    localparam logic CMD_RESET = 1'b0;

    // Width of a down-counter that must hold the larger of the two phase lengths.
    function automatic int cnt_width(input int pulse_cycles, input int settle_cycles);
        int m;
        m = (pulse_cycles > settle_cycles) ? pulse_cycles : settle_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rs_latch_sequencer_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rs_latch_sequencer_rr_arbiter
// Round-robin arbiter. The winner is the first asserted request at or above
// the pointer, wrapping from NUM_REQ-1 back to 0. The pointer moves to one
// past the winner whenever Advance is pulsed while a request is pending.
// Ports:
//   Clk      in   system clock (rising edge)
//   Reset_n  in   synchronous active-low reset (pointer -> 0)
//   Req      in   per-requester request vector
//   Advance  in   accept the current winner and move the pointer
//   Winner   out  one-hot winner (combinational, zero when no request)
//   Any      out  at least one request is asserted
// -----------------------------------------------------------------------------
module rs_latch_sequencer_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [NUM_REQ-1:0] Req,
    input  logic               Advance,
    output logic [NUM_REQ-1:0] Winner,
    output logic               Any
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win_idx_s;
    logic             hit_s;
    logic             any_s;

    // Winner search in two passes: first at/above the pointer, then the wrap-around part.
    always_comb begin
        hit_s     = 1'b0;
        win_idx_s = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!hit_s && Req[j] && (PTR_W'(j) >= ptr_q)) begin
                hit_s     = 1'b1;
                win_idx_s = PTR_W'(j);
            end else begin
                hit_s = hit_s;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!hit_s && Req[j] && (PTR_W'(j) < ptr_q)) begin
                hit_s     = 1'b1;
                win_idx_s = PTR_W'(j);
            end else begin
                hit_s = hit_s;
            end
        end
        any_s = |Req;
        if (any_s) begin
            Winner = ONE_HOT0 << win_idx_s;
        end else begin
            Winner = '0;
        end
        if (win_idx_s == LAST_IDX) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_idx_s + PTR_W'(1);
        end
    end

    assign Any = any_s;

    // Pointer register: steps one past the winner on each accepted grant.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ptr_q <= '0;
        end else if (Advance && any_s) begin
            ptr_q <= ptr_d;
        end else begin
            ptr_q <= ptr_q;
        end
    end

endmodule

// File: rtl/rs_latch_sequencer.sv
// -----------------------------------------------------------------------------
// rs_latch_sequencer
// Shares one RS latch between NUM_REQ requesters. Each granted command is
// played out as a fixed-width S (set) or R (reset) pulse followed by a settle
// gap with S=R=0; Q is then captured and returned with a one-cycle Done.
// S and R come straight from registers and are never high together.
// Ports:
//   Clk       in   system clock (rising edge)
//   Reset_n   in   synchronous active-low reset
//   Req       in   per-requester request, held until its Done
//   Cmd       in   per-requester command (1 = set, 0 = reset)
//   Gnt       out  one-hot grant, high from GRANT through DONE
//   Done      out  one-cycle completion pulse, Q_sample valid
//   Q_sample  out  latch Q captured on entry to DONE
//   Busy      out  high whenever the FSM is not idle
//   S, R      out  latch set/reset drives
//   Q         in   latch output
// -----------------------------------------------------------------------------
module rs_latch_sequencer
    import rs_latch_sequencer_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [NUM_REQ-1:0] Cmd,
    output logic [NUM_REQ-1:0] Gnt,
    output logic               Done,
    output logic               Q_sample,
    output logic               Busy,
    output logic               S,
    output logic               R,
    input  logic               Q
);

    localparam int CNT_W = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cmd_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               done_q;
    logic               q_sample_q;
    logic               busy_q;
    logic               s_q;
    logic               r_q;

    logic [NUM_REQ-1:0] winner_s;
    logic               any_s;
    logic               advance_s;
    logic               cmd_sel_s;

    // The pointer only moves when IDLE actually hands out a grant.
    assign advance_s = (state_q == ST_IDLE) && any_s;

    // Command of the granted requester; only looked at in GRANT.
    assign cmd_sel_s = |(Cmd & gnt_q);

    rs_latch_sequencer_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Req     (Req),
        .Advance (advance_s),
        .Winner  (winner_s),
        .Any     (any_s)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_q      <= CMD_RESET;
            gnt_q      <= '0;
            done_q     <= 1'b0;
            q_sample_q <= 1'b0;
            busy_q     <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_s) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= winner_s;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Command is frozen here; later Cmd changes are ignored.
                    cmd_q   <= cmd_sel_s;
                    s_q     <= (cmd_sel_s == CMD_SET);
                    r_q     <= (cmd_sel_s == CMD_RESET);
                    cnt_q   <= PULSE_LOAD;
                    state_q <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (cnt_q == CNT_ONE) begin
                        s_q <= 1'b0;
                        r_q <= 1'b0;
                        if (SETTLE_CYCLES > 0) begin
                            state_q <= ST_SETTLE;
                            cnt_q   <= SETTLE_LOAD;
                        end else begin
                            // No settle gap: Q has been stable since the pulse started.
                            state_q    <= ST_DONE;
                            cnt_q      <= '0;
                            done_q     <= 1'b1;
                            q_sample_q <= Q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                        s_q   <= (cmd_q == CMD_SET);
                        r_q   <= (cmd_q == CMD_RESET);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q    <= ST_DONE;
                        cnt_q      <= '0;
                        done_q     <= 1'b1;
                        q_sample_q <= Q;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // Grant drops here so the requester re-competes from IDLE.
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                end
            endcase
        end
    end

    assign Gnt      = gnt_q;
    assign Done     = done_q;
    assign Q_sample = q_sample_q;
    assign Busy     = busy_q;
    assign S        = s_q;
    assign R        = r_q;

endmodule

// File: tb/tb_rs_latch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rs_latch_sequencer
// Directed bench: instance A uses default parameters, instance B uses
// NUM_REQ=4, PULSE_CYCLES=1, SETTLE_CYCLES=0. Each drives a behavioural RS latch.
// -----------------------------------------------------------------------------
module tb_rs_latch_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_a, cmd_a, gnt_a;
    logic       done_a, qs_a, busy_a, s_a, r_a;
    logic       q_a = 1'b0;
    logic [3:0] req_b, cmd_b, gnt_b;
    logic       done_b, qs_b, busy_b, s_b, r_b;
    logic       q_b = 1'b0;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  last_done;
    bit  mon_en = 1'b0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    rs_latch_sequencer #(
        .NUM_REQ(2), .PULSE_CYCLES(2), .SETTLE_CYCLES(1)
    ) u_dut_a (
        .Clk(clk), .Reset_n(rst_n), .Req(req_a), .Cmd(cmd_a), .Gnt(gnt_a),
        .Done(done_a), .Q_sample(qs_a), .Busy(busy_a), .S(s_a), .R(r_a), .Q(q_a)
    );

    rs_latch_sequencer #(
        .NUM_REQ(4), .PULSE_CYCLES(1), .SETTLE_CYCLES(0)
    ) u_dut_b (
        .Clk(clk), .Reset_n(rst_n), .Req(req_b), .Cmd(cmd_b), .Gnt(gnt_b),
        .Done(done_b), .Q_sample(qs_b), .Busy(busy_b), .S(s_b), .R(r_b), .Q(q_b)
    );

    // Behavioural RS latches: hold state unless exactly one of S/R is high.
    always @(s_a or r_a) begin
        if (s_a === 1'b1 && r_a !== 1'b1) q_a = 1'b1;
        else if (r_a === 1'b1 && s_a !== 1'b1) q_a = 1'b0;
    end
    always @(s_b or r_b) begin
        if (s_b === 1'b1 && r_b !== 1'b1) q_b = 1'b1;
        else if (r_b === 1'b1 && s_b !== 1'b1) q_b = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_done(input bit on_b, input int max_cyc);
        int n;
        n = 0;
        while (((on_b ? done_b : done_a) !== 1'b1) && (n < max_cyc)) begin
            step();
            n++;
        end
        chk(on_b ? "b_done_seen" : "a_done_seen", 32'(on_b ? done_b : done_a), 32'd1);
    endtask

    // S and R must never be high together on either instance.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("a_no_s_and_r", 32'(s_a & r_a), 32'd0);
            chk("b_no_s_and_r", 32'(s_b & r_b), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // T1: reset with both requests pending
        rst_n = 1'b0; req_a = 2'b11; cmd_a = 2'b00; req_b = 4'b0000; cmd_b = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            mon_en = 1'b1;
            chk("t1_s", 32'(s_a), 32'd0);
            chk("t1_r", 32'(r_a), 32'd0);
            chk("t1_gnt", 32'(gnt_a), 32'd0);
            chk("t1_done", 32'(done_a), 32'd0);
            chk("t1_busy", 32'(busy_a), 32'd0);
            chk("t1_qs", 32'(qs_a), 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk("t1_first_gnt", 32'(gnt_a), 32'd1);
        req_a = 2'b00;
        wait_done(1'b0, 10);
        step();
        chk("t1_idle_busy", 32'(busy_a), 32'd0);

        // T2: single set from requester 0, cycle-exact
        req_a = 2'b01; cmd_a = 2'b01;
        step();
        chk("t2_gnt_k1", 32'(gnt_a), 32'd1);
        chk("t2_s_k1", 32'(s_a), 32'd0);
        step();
        chk("t2_s_k2", 32'(s_a), 32'd1);
        chk("t2_r_k2", 32'(r_a), 32'd0);
        step();
        chk("t2_s_k3", 32'(s_a), 32'd1);
        step();
        chk("t2_s_k4", 32'(s_a), 32'd0);
        chk("t2_r_k4", 32'(r_a), 32'd0);
        chk("t2_done_k4", 32'(done_a), 32'd0);
        step();
        chk("t2_done_k5", 32'(done_a), 32'd1);
        chk("t2_qs_k5", 32'(qs_a), 32'd1);
        chk("t2_busy_k5", 32'(busy_a), 32'd1);
        req_a = 2'b00;
        step();
        chk("t2_gnt_k6", 32'(gnt_a), 32'd0);
        chk("t2_done_k6", 32'(done_a), 32'd0);
        chk("t2_busy_k6", 32'(busy_a), 32'd0);
        chk("t2_qs_hold", 32'(qs_a), 32'd1);

        // T3: contention from pointer 0, requester 0 resets, requester 1 sets
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        req_a = 2'b11; cmd_a = 2'b10;
        for (int i = 0; i < 4; i++) begin
            wait_done(1'b0, 12);
            chk("t3_gnt", 32'(gnt_a), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("t3_qs", 32'(qs_a), (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i > 0) chk("t3_gap", 32'(cyc - last_done), 32'd6);
            last_done = cyc;
            if (i < 3) step();
        end
        req_a = 2'b00;
        step();

        // T4: reset during the second PULSE cycle of a set
        req_a = 2'b01; cmd_a = 2'b01;
        step();
        chk("t4_gnt", 32'(gnt_a), 32'd1);
        step();
        chk("t4_s_p1", 32'(s_a), 32'd1);
        step();
        chk("t4_s_p2", 32'(s_a), 32'd1);
        rst_n = 1'b0;
        step();
        chk("t4_s_cut", 32'(s_a), 32'd0);
        chk("t4_r_cut", 32'(r_a), 32'd0);
        chk("t4_gnt_cut", 32'(gnt_a), 32'd0);
        chk("t4_busy_cut", 32'(busy_a), 32'd0);
        chk("t4_no_done", 32'(done_a), 32'd0);
        step();
        chk("t4_no_done2", 32'(done_a), 32'd0);
        rst_n = 1'b1; req_a = 2'b11; cmd_a = 2'b00;
        step();
        chk("t4_ptr_zero", 32'(gnt_a), 32'd1);
        req_a = 2'b00;
        wait_done(1'b0, 10);
        chk("t4_qs", 32'(qs_a), 32'd0);
        step();

        // T5: requester 1 withdraws early, requester 0 arrives meanwhile
        req_a = 2'b10; cmd_a = 2'b00;
        step();
        chk("t5_gnt1", 32'(gnt_a), 32'd2);
        step();
        req_a = 2'b01;
        chk("t5_r_p1", 32'(r_a), 32'd1);
        chk("t5_s_p1", 32'(s_a), 32'd0);
        step();
        chk("t5_r_p2", 32'(r_a), 32'd1);
        step();
        chk("t5_r_off", 32'(r_a), 32'd0);
        step();
        chk("t5_done", 32'(done_a), 32'd1);
        chk("t5_gnt_done", 32'(gnt_a), 32'd2);
        step();
        chk("t5_idle_gnt", 32'(gnt_a), 32'd0);
        chk("t5_idle_busy", 32'(busy_a), 32'd0);
        step();
        chk("t5_gnt0", 32'(gnt_a), 32'd1);
        req_a = 2'b00;
        wait_done(1'b0, 10);
        chk("t5_qs0", 32'(qs_a), 32'd0);
        step();

        // T6: NUM_REQ=4, PULSE=1, SETTLE=0, all requesting
        req_b = 4'b1111; cmd_b = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            wait_done(1'b1, 8);
            chk("t6_gnt", 32'(gnt_b), 32'(4'b0001 << (i % 4)));
            chk("t6_qs", 32'(qs_b), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i > 0) chk("t6_gap", 32'(cyc - last_done), 32'd4);
            last_done = cyc;
            if (i < 4) step();
        end
        req_b = 4'b0000;
        step();
        step();
        chk("t6_idle_busy", 32'(busy_b), 32'd0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
